// File: rtl/clock_pio_out.sv
// clock_pio_out: Avalon-MM output port with DATA/SET/CLEAR/TOGGLE and optional blink (CLOCK_PIO_OUT_BLINK_EN).
// Read latency 1, no stalls; out_port is registered one cycle behind DATA and blink phase.
module clock_pio_out #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          PRESC_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_MASK   = 3'd4;
  localparam logic [2:0] ADDR_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_data_nxt;
  logic [WIDTH-1:0] w_blink;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wd;

  logic [WIDTH-1:0] r_data;
  logic [31:0]      r_readdata;
  logic [WIDTH-1:0] r_out_port;

  assign w_wr        = chipselect && !write_n;
  assign w_rd        = chipselect && !read_n;
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_unused_wd = ^writedata;

  always_comb begin
    w_data_nxt = r_data;
    if (w_wr) begin
      case (address)
        ADDR_DATA:   w_data_nxt = w_wd;
        ADDR_SET:    w_data_nxt = r_data | w_wd;
        ADDR_CLEAR:  w_data_nxt = r_data & ~w_wd;
        ADDR_TOGGLE: w_data_nxt = r_data ^ w_wd;
        default:     w_data_nxt = r_data;
      endcase
    end
  end

`ifdef CLOCK_PIO_OUT_BLINK_EN
  logic [WIDTH-1:0]       r_blink_mask;
  logic [PRESC_WIDTH-1:0] r_blink_period;
  logic [PRESC_WIDTH-1:0] r_count;
  logic                   r_phase;
  logic                   w_period_wr;

  assign w_period_wr = w_wr && (address == ADDR_PERIOD);

  // A period write restarts the blink from phase 0 so the new rate takes effect cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_mask   <= '0;
      r_blink_period <= '0;
      r_count        <= '0;
      r_phase        <= 1'b0;
    end else begin
      if (w_wr && (address == ADDR_MASK)) begin
        r_blink_mask <= w_wd;
      end
      if (w_period_wr) begin
        r_blink_period <= writedata[PRESC_WIDTH-1:0];
        r_count        <= '0;
        r_phase        <= 1'b0;
      end else if (r_blink_period == '0) begin
        r_count <= '0;
        r_phase <= 1'b0;
      end else if (r_count == r_blink_period - PRESC_WIDTH'(1)) begin
        r_count <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_count <= r_count + PRESC_WIDTH'(1);
      end
    end
  end

  assign w_blink = r_blink_mask & {WIDTH{r_phase}};
`else
  assign w_blink = '0;
`endif

  // Mux sees pre-write register values, so a read racing a write returns the old value.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR, ADDR_TOGGLE: w_rd_mux[WIDTH-1:0] = r_data;
`ifdef CLOCK_PIO_OUT_BLINK_EN
      ADDR_MASK:   w_rd_mux[WIDTH-1:0]       = r_blink_mask;
      ADDR_PERIOD: w_rd_mux[PRESC_WIDTH-1:0] = r_blink_period;
      ADDR_STATUS: w_rd_mux[0]               = r_phase;
`endif
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= RESET_VALUE[WIDTH-1:0];
      r_readdata <= '0;
      r_out_port <= RESET_VALUE[WIDTH-1:0];
    end else begin
      r_data     <= w_data_nxt;
      r_out_port <= r_data ^ w_blink;
      if (w_rd) begin
        r_readdata <= w_rd_mux;
      end
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_out_port;

endmodule

// File: doc/clock_pio_out.md
CLOCK_PIO_OUT -- requirements
Module: clock_pio_out

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, output port width (1..32).
REQ-002 SHALL provide parameter RESET_VALUE, default 0, DATA register value after reset.
REQ-003 SHALL provide parameter PRESC_WIDTH, default 24, width of BLINK_PERIOD register and blink counter (1..32).
REQ-004 SHALL provide port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL provide port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port address  input  3  Avalon-MM word offset.
REQ-007 SHALL provide port chipselect  input  1  slave select.
REQ-008 SHALL provide port write_n  input  1  active-low write strobe.
REQ-009 SHALL provide port read_n  input  1  active-low read strobe.
REQ-010 SHALL provide port writedata  input  32  write data; bits above WIDTH/PRESC_WIDTH ignored.
REQ-011 SHALL provide port readdata  output  32  registered read data, upper unused bits zero.
REQ-012 SHALL provide port out_port  output  WIDTH  driven output pins.

Function
REQ-013 SHALL decode write when chipselect=1 and write_n=0; read when chipselect=1 and read_n=0.
REQ-014 SHALL implement map: 0 DATA (R/W), 1 SET (W), 2 CLEAR (W), 3 TOGGLE (W), 4 BLINK_MASK (R/W), 5 BLINK_PERIOD (R/W), 6 STATUS (R), 7 reserved (reads 0, writes ignored).
REQ-015 SHALL on SET write: DATA <= DATA | writedata[WIDTH-1:0]; CLEAR: DATA <= DATA & ~wd; TOGGLE: DATA <= DATA ^ wd; all one-cycle read-modify-write, no bus stall.
REQ-016 SHALL return DATA on reads of offsets 0..3.
REQ-017 SHALL register readdata: value captured on the read cycle, visible next cycle (read latency 1); readdata holds last value when no read.
REQ-018 SHALL, for a read coinciding with a write to the same register, return the pre-write value.
REQ-019 SHALL run blink counter: when BLINK_PERIOD=P>0, counter increments every cycle; at count P-1 counter <= 0 and phase toggles (phase half-period = P cycles).
REQ-020 SHALL hold counter=0 and phase=0 while BLINK_PERIOD=0.
REQ-021 SHALL clear counter and phase on every BLINK_PERIOD write, new period effective the cycle after the write.
REQ-022 SHALL drive out_port = DATA ^ (BLINK_MASK & {WIDTH{phase}}), registered (one cycle after DATA/phase change).
REQ-023 SHALL report STATUS bit0 = phase, bits [31:1] = 0.
REQ-024 SHALL wrap counter only via REQ-019; no overflow path exists since counter < P <= 2^PRESC_WIDTH-1.

Reset
REQ-025 SHALL on reset_n=0 asynchronously set DATA=RESET_VALUE, BLINK_MASK=0, BLINK_PERIOD=0, counter=0, phase=0, readdata=0, out_port=RESET_VALUE[WIDTH-1:0].
REQ-026 SHALL abort any in-flight read on mid-operation reset; first read after release returns normal data with latency 1.

Configuration
REQ-027 SHALL compile blink logic (BLINK_MASK, BLINK_PERIOD, counter, phase, STATUS) only when macro CLOCK_PIO_OUT_BLINK_EN is defined.
REQ-028 SHALL, without CLOCK_PIO_OUT_BLINK_EN, read 0 at offsets 4..6, ignore writes there, and drive out_port = DATA registered.

Verification
REQ-029 SHALL cover: reset, WIDTH=8, RESET_VALUE=0x5A -> out_port=0x5A, read offset 0 returns 0x0000005A one cycle after read.
REQ-030 SHALL cover: DATA=0x0F; SET 0xF0 -> 0xFF; CLEAR 0x81 -> 0x7E; TOGGLE 0xFF -> 0x81 on out_port one cycle after each write.
REQ-031 SHALL cover: DATA=0x00, BLINK_MASK=0x03, BLINK_PERIOD=4 -> out_port alternates 0x00/0x03 every 4 cycles; STATUS bit0 tracks phase.
REQ-032 SHALL cover: mid-blink write BLINK_PERIOD=0 -> phase=0, out_port=DATA steady for 100 cycles.
REQ-033 SHALL cover: simultaneous read and write to DATA (0x11 -> 0x22) -> readdata=0x11, subsequent read 0x22.
REQ-034 SHALL cover: reset_n pulsed low during blink with DATA=0xAA -> all registers at reset values immediately, out_port=RESET_VALUE without clock edge.
